// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: serialises the core's instruction-bus and data-bus
// requests onto the single shared cache bus (CBus), one transaction at a time.
// Each grant is latched into a request buffer, so every creq field stays
// stable for the whole transaction. The completion handshake and read data
// are returned to the requester for exactly one cycle.
//
// Optional feature, macro ARB_ROUND_ROBIN_EN:
//   defined   - round-robin between the buses when both request in IDLE
//   undefined - fixed priority, the data bus always wins
module core_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction bus from the core
  input  logic                  ireq_valid,
  input  logic [ADDR_W-1:0]     ireq_addr,
  output logic                  iresp_addr_ok,
  output logic                  iresp_data_ok,
  output logic [31:0]           iresp_data,
  // data bus from the core memory stage
  input  logic                  dreq_valid,
  input  logic [ADDR_W-1:0]     dreq_addr,
  input  logic [2:0]            dreq_size,
  input  logic [DATA_W/8-1:0]   dreq_strobe,
  input  logic [DATA_W-1:0]     dreq_data,
  output logic                  dresp_addr_ok,
  output logic                  dresp_data_ok,
  output logic [DATA_W-1:0]     dresp_data,
  // shared cache bus toward memory
  output logic                  creq_valid,
  output logic                  creq_is_write,
  output logic [2:0]            creq_size,
  output logic [ADDR_W-1:0]     creq_addr,
  output logic [DATA_W/8-1:0]   creq_strobe,
  output logic [DATA_W-1:0]     creq_data,
  output logic [3:0]            creq_len,
  output logic [1:0]            creq_burst,
  input  logic                  cresp_ready,
  input  logic                  cresp_last,
  input  logic [DATA_W-1:0]     cresp_data
);

  localparam logic [2:0] MSIZE4          = 3'd2;
  localparam logic [3:0] MLEN1           = 4'd0;
  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IBUS, OWN_DBUS} owner_t;

  state_t state;
  owner_t owner;
  logic   flushed;
  logic   prefer_d;
  logic   grant_d;
  logic   grant_i;
  logic   owner_valid;

  // Every transaction is a single beat, so the ready beat is always the last
  // one; last carries no extra information here.
  logic   unused_last;
  assign unused_last = cresp_last;

`ifdef ARB_ROUND_ROBIN_EN
  // 0: instruction bus was served last, 1: data bus was served last
  logic last_owner;

  // Prefer the data bus only when the instruction bus had the previous turn
  assign prefer_d = (last_owner == 1'b0);

  // Remember which side received the most recent grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= 1'b0;
    end else if (state == IDLE && grant_d) begin
      last_owner <= 1'b1;
    end else if (state == IDLE && grant_i) begin
      last_owner <= 1'b0;
    end
  end
`else
  // Fixed priority: the data bus always wins a tie
  assign prefer_d = 1'b1;
`endif

  // Grant decision and the current owner's live request valid
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise an
    // unassigned path would infer a latch.
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    owner_valid = 1'b0;
    grant_d     = dreq_valid && (prefer_d || !ireq_valid);
    grant_i     = ireq_valid && !grant_d;
    case (owner)
      OWN_IBUS: owner_valid = ireq_valid;
      OWN_DBUS: owner_valid = dreq_valid;
      default:  owner_valid = 1'b0;
    endcase
  end

  // Arbiter FSM: grant and latch in IDLE, hold CBus in BUSY, respond in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the request and response buffers are plain registers, not a
      // memory, so all of them are cleared; creq must read all-zero in reset.
      state         <= IDLE;
      owner         <= OWN_NONE;
      flushed       <= 1'b0;
      creq_valid    <= 1'b0;
      creq_is_write <= 1'b0;
      creq_size     <= '0;
      creq_addr     <= '0;
      creq_strobe   <= '0;
      creq_data     <= '0;
      creq_len      <= '0;
      creq_burst    <= '0;
      iresp_addr_ok <= 1'b0;
      iresp_data_ok <= 1'b0;
      iresp_data    <= '0;
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this
      // block sees the value from before the clock edge.
      // Responses are one-cycle pulses; these registers double as the
      // response buffer and are zero outside the owner's DONE cycle.
      iresp_addr_ok <= 1'b0;
      iresp_data_ok <= 1'b0;
      iresp_data    <= '0;
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= '0;
      case (state)
        IDLE: begin
          flushed <= 1'b0;
          if (grant_d) begin
            owner         <= OWN_DBUS;
            creq_valid    <= 1'b1;
            creq_is_write <= (dreq_strobe != '0);
            creq_size     <= dreq_size;
            creq_addr     <= dreq_addr;
            creq_strobe   <= dreq_strobe;
            creq_data     <= dreq_data;
            creq_len      <= MLEN1;
            creq_burst    <= AXI_BURST_FIXED;
            state         <= BUSY;
          end else if (grant_i) begin
            owner         <= OWN_IBUS;
            creq_valid    <= 1'b1;
            creq_is_write <= 1'b0;
            creq_size     <= MSIZE4;
            creq_addr     <= ireq_addr;
            creq_strobe   <= '0;
            creq_data     <= '0;
            creq_len      <= MLEN1;
            creq_burst    <= AXI_BURST_FIXED;
            state         <= BUSY;
          end
        end
        BUSY: begin
          // A dropped valid marks the transaction flushed for good, even if
          // the requester raises valid again before the beat completes.
          if (!owner_valid) begin
            flushed <= 1'b1;
          end
          if (cresp_ready) begin
            creq_valid <= 1'b0;
            state      <= DONE;
            if (!flushed && owner_valid) begin
              if (owner == OWN_IBUS) begin
                iresp_addr_ok <= 1'b1;
                iresp_data_ok <= 1'b1;
                iresp_data    <= cresp_data[31:0];
              end else begin
                dresp_addr_ok <= 1'b1;
                dresp_data_ok <= 1'b1;
                dresp_data    <= creq_is_write ? '0 : cresp_data;
              end
            end
          end
        end
        DONE: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: scoreboard bench for core_bus_arbiter. Expected CBus
// requests and core responses are queued as stimulus is driven; a monitor
// pops and compares them when the DUT produces them, and a small memory
// model answers CBus requests after a programmable delay.
module tb_core_bus_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk;
  logic              reset;
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_addr_ok;
  logic              iresp_data_ok;
  logic [31:0]       iresp_data;
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;
  logic              creq_valid;
  logic              creq_is_write;
  logic [2:0]        creq_size;
  logic [ADDR_W-1:0] creq_addr;
  logic [7:0]        creq_strobe;
  logic [DATA_W-1:0] creq_data;
  logic [3:0]        creq_len;
  logic [1:0]        creq_burst;
  logic              cresp_ready;
  logic              cresp_last;
  logic [DATA_W-1:0] cresp_data;

  core_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
    .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .creq_len(creq_len), .creq_burst(creq_burst),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Flattened views of the DUT request and response buses
  logic [255:0] creq_vec;
  logic [255:0] resp_vec;
  assign creq_vec = 256'({creq_is_write, creq_size, creq_len, creq_burst,
                          creq_strobe, creq_addr, creq_data});
  assign resp_vec = 256'({iresp_addr_ok, iresp_data_ok, iresp_data,
                          dresp_addr_ok, dresp_data_ok, dresp_data});

  logic [255:0] exp_creq[$];
  logic [255:0] exp_resp[$];
  logic [63:0]  mem_data[$];

  // Expected encodings: MSIZE4 = 2, MLEN1 = 0, AXI_BURST_FIXED = 0
  function automatic logic [255:0] mk_creq(input logic w, input logic [2:0] size,
      input logic [7:0] strb, input logic [63:0] addr, input logic [63:0] data);
    return 256'({w, size, 4'd0, 2'd0, strb, addr, data});
  endfunction

  task automatic push_fetch(input logic [63:0] addr, input logic [63:0] rdata);
    exp_creq.push_back(mk_creq(1'b0, 3'd2, 8'h00, addr, 64'd0));
    mem_data.push_back(rdata);
    exp_resp.push_back(256'({1'b1, 1'b1, rdata[31:0], 1'b0, 1'b0, 64'd0}));
  endtask

  task automatic push_data(input logic [63:0] addr, input logic [2:0] size,
      input logic [7:0] strb, input logic [63:0] wdata, input logic [63:0] rdata);
    logic w;
    logic [63:0] rd;
    w  = (strb != 8'h00);
    rd = w ? 64'd0 : rdata;
    exp_creq.push_back(mk_creq(w, size, strb, addr, wdata));
    mem_data.push_back(rdata);
    exp_resp.push_back(256'({1'b0, 1'b0, 32'd0, 1'b1, 1'b1, rd}));
  endtask

  // Memory model: answers each CBus request after mem_delay cycles
  int          mem_delay = 0;
  int          mem_cnt   = 0;
  logic        rsp_ready = 1'b0;
  logic        spur_ready = 1'b0;
  logic [63:0] rsp_data  = '0;
  assign cresp_ready = rsp_ready | spur_ready;
  assign cresp_last  = rsp_ready | spur_ready;
  assign cresp_data  = rsp_data;

  always @(negedge clk) begin
    if (reset) begin
      rsp_ready = 1'b0;
      mem_cnt   = 0;
    end else if (rsp_ready) begin
      rsp_ready = 1'b0;
      mem_cnt   = 0;
    end else if (creq_valid) begin
      if (mem_cnt >= mem_delay) begin
        rsp_ready = 1'b1;
        rsp_data  = (mem_data.size() != 0) ? mem_data.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        mem_cnt++;
      end
    end
  end

  // Monitor: request fields on issue, stability while valid, responses
  logic         prev_valid = 1'b0;
  logic [255:0] held_creq  = '0;
  int           cv_cycles  = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (creq_valid) begin
        cv_cycles++;
        if (!prev_valid) begin
          if (exp_creq.size() == 0) check("creq_unexpected", creq_valid, 0);
          else check("creq_fields", creq_vec, exp_creq.pop_front());
        end else begin
          check("creq_stable", creq_vec, held_creq);
        end
        held_creq = creq_vec;
      end
      prev_valid = creq_valid;
      if (iresp_data_ok || dresp_data_ok) begin
        if (exp_resp.size() == 0) check("resp_unexpected", resp_vec, 0);
        else check("resp", resp_vec, exp_resp.pop_front());
      end else begin
        check("resp_quiet", resp_vec, 0);
      end
    end
  end

  // Hold requests until their data_ok, then drain to IDLE
  task automatic serve(input string tag, input int budget);
    int n;
    n = 0;
    while ((ireq_valid || dreq_valid || creq_valid || exp_resp.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (iresp_data_ok) ireq_valid = 1'b0;
      if (dresp_data_ok) dreq_valid = 1'b0;
    end
    check({tag, "_timeout"}, 256'(n < budget), 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    reset = 1'b1;
    ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    repeat (2) @(negedge clk);
    check("reset_creq", 256'({creq_valid, creq_vec[145:0]}), 0);
    check("reset_resp", resp_vec, 0);
    reset = 1'b0;
    @(negedge clk);

    // Instruction fetch: request cycle 0, creq cycle 1, data_ok cycle 2
    mem_delay = 0;
    push_fetch(64'h8000_0000, 64'h0000_0000_0010_0093);
    ireq_addr = 64'h8000_0000; ireq_valid = 1'b1;
    t0 = cyc;
    n = 0;
    while (!iresp_data_ok && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_latency", cyc - t0, 2);
    ireq_valid = 1'b0;
    @(negedge clk);
    check("fetch_pulse", iresp_data_ok, 0);
    @(negedge clk);

    // Data store with a slow memory; core changes addr/data mid-transaction
    mem_delay = 4;
    cv_cycles = 0;
    push_data(64'h8000_1000, 3'd2, 8'h0F, 64'h1234_5678, 64'hDEAD_BEEF_DEAD_BEEF);
    dreq_addr = 64'h8000_1000; dreq_size = 3'd2; dreq_strobe = 8'h0F;
    dreq_data = 64'h1234_5678; dreq_valid = 1'b1;
    repeat (3) @(negedge clk);
    dreq_addr = 64'h8000_1FF0; dreq_data = 64'h5555_AAAA;
    serve("store", 40);
    check("store_valid_cycles", cv_cycles, 5);

    // Contention right after a data-bus grant
    mem_delay = 1;
`ifdef ARB_ROUND_ROBIN_EN
    push_fetch(64'h8000_0100, 64'h1111_2222_0000_0013);
    push_data(64'h8000_2000, 3'd3, 8'h00, 64'h0, 64'hCAFE_BABE_0BAD_F00D);
`else
    push_data(64'h8000_2000, 3'd3, 8'h00, 64'h0, 64'hCAFE_BABE_0BAD_F00D);
    push_fetch(64'h8000_0100, 64'h1111_2222_0000_0013);
`endif
    ireq_addr = 64'h8000_0100;
    dreq_addr = 64'h8000_2000; dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_data = 64'h0;
    ireq_valid = 1'b1; dreq_valid = 1'b1;
    serve("contend", 60);
    check("contend_drained", exp_creq.size(), 0);

    // Ready pulses while IDLE must not start anything
    spur_ready = 1'b1;
    repeat (3) @(negedge clk);
    spur_ready = 1'b0;
    check("spur_idle", creq_valid, 0);
    @(negedge clk);

    // Flush: ibus drops valid two cycles into BUSY, raises and drops again
    mem_delay = 4;
    exp_creq.push_back(mk_creq(1'b0, 3'd2, 8'h00, 64'h8000_0200, 64'd0));
    mem_data.push_back(64'h0000_0000_ABCD_0001);
    ireq_addr = 64'h8000_0200; ireq_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) ireq_valid = 1'b0;
      if (k == 3) ireq_valid = 1'b1;
      if (k == 4) ireq_valid = 1'b0;
    end
    check("flush_idle", creq_valid, 0);
    check("flush_beat_done", mem_data.size(), 0);
    check("flush_no_resp", exp_resp.size(), 0);

    // Follow-up fetch proves the FSM is back in IDLE
    mem_delay = 0;
    push_fetch(64'h8000_0204, 64'h0000_0000_0040_0113);
    ireq_addr = 64'h8000_0204; ireq_valid = 1'b1;
    serve("post_flush", 30);

    // Asynchronous reset in the middle of a transaction
    mem_delay = 6;
    push_fetch(64'h8000_0300, 64'h0);
    ireq_addr = 64'h8000_0300; ireq_valid = 1'b1;
    n = 0;
    while (!creq_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_busy_seen", creq_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_creq_valid", creq_valid, 0);
    check("rst_creq_fields", creq_vec, 0);
    check("rst_resp", resp_vec, 0);
    ireq_valid = 1'b0;
    exp_creq.delete();
    exp_resp.delete();
    mem_data.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_delay = 1;
    push_fetch(64'h8000_0400, 64'h0000_0000_0000_0073);
    ireq_addr = 64'h8000_0400; ireq_valid = 1'b1;
    serve("post_reset", 30);
    check("final_creq_drained", exp_creq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
